// File: rtl/spdif_pkg.sv
// spdif_pkg: shared constants and helpers for the S/PDIF stream transmitter.
// Holds the preamble half-cell patterns, subframe slot indices, block length
// and the builder for the consumer channel-status word.
package spdif_pkg;

    // Preamble half-cell patterns, first transmitted half-cell in bit 7.
    localparam logic [7:0] PRE_Z = 8'b11101000;
    localparam logic [7:0] PRE_X = 8'b11100010;
    localparam logic [7:0] PRE_Y = 8'b11100100;

    // Subframe slot indices.
    localparam logic [4:0] SLOT_PRE_LAST = 5'd3;
    localparam logic [4:0] SLOT_AUDIO0   = 5'd4;
    localparam logic [4:0] SLOT_V        = 5'd28;
    localparam logic [4:0] SLOT_U        = 5'd29;
    localparam logic [4:0] SLOT_C        = 5'd30;
    localparam logic [4:0] SLOT_P        = 5'd31;

    // Block framing and the width of the audio slot.
    localparam logic [7:0] FRAMES_PER_BLOCK = 8'd192;
    localparam logic [7:0] CS_WORD_FRAMES   = 8'd32;
    localparam int         AUDIO_SLOT_W     = 24;

    typedef enum logic {
        SUB_LEFT  = 1'b0,
        SUB_RIGHT = 1'b1
    } sub_t;

    // Consumer channel-status word, transmitted MSB first from frame 0.
    // [31] pro, [30] non-audio, [29] copy, [28:26] pre-emphasis, [25:24] mode,
    // [23:17] category, [16] generation, [15:12] source, [11:8] channel,
    // [7:4] sample frequency, [3:2] clock accuracy, [1:0] reserved.
    function automatic logic [31:0] build_cs(input logic [6:0] category,
                                             input logic       copy,
                                             input logic       l_bit,
                                             input logic [3:0] freq);
        logic [31:0] cs;
        cs        = 32'h0000_0000;
        cs[29]    = copy;
        cs[23:17] = category;
        cs[16]    = l_bit;
        cs[7:4]   = freq;
        return cs;
    endfunction

endpackage

// File: rtl/spdif_sample_fifo.sv
// spdif_sample_fifo: synchronous FIFO of stereo sample pairs.
// Count-register based full/empty; a push into a full FIFO is ignored, a pop
// from an empty FIFO is ignored. DEPTH must be a power of two, >= 2.
module spdif_sample_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1'b1);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(1'b0);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_s;
    logic             pop_s;

    assign full    = (count_r == CNT_FULL);
    assign empty   = (count_r == CNT_ZERO);
    assign push_s  = wr_en && !full;
    assign pop_s   = rd_en && !empty;
    assign rd_data = mem_r[rd_ptr_r];

    // Storage array: written on accepted pushes, contents need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy count; reset discards everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spdif_tx_stream.sv
// spdif_tx_stream: consumer S/PDIF stereo transmitter with input sample FIFO.
// One half-cell of biphase-mark line output is produced per i_en_2x strobe.
// A stereo pair is popped when the left preamble is loaded and held for both
// subframes; an empty FIFO at that point sends zero audio flagged invalid.
// Optional feature macro: SPDIF_TX_CS_PORT_EN adds i_cs, a channel-status
// word captured at every block start; otherwise the word is built from the
// CATEGORY_CODE/COPY_BIT/L_BIT/SAMPLE_FREQ parameters.
module spdif_tx_stream
    import spdif_pkg::*;
#(
    parameter int         SAMPLE_W      = 24,
    parameter int         FIFO_DEPTH    = 4,
    parameter logic [6:0] CATEGORY_CODE = 7'b0110000,
    parameter logic       COPY_BIT      = 1'b1,
    parameter logic       L_BIT         = 1'b0,
    parameter logic [3:0] SAMPLE_FREQ   = 4'b0000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en_2x,
    input  logic [SAMPLE_W-1:0] i_ldata,
    input  logic [SAMPLE_W-1:0] i_rdata,
    input  logic                i_valid,
`ifdef SPDIF_TX_CS_PORT_EN
    input  logic [31:0]         i_cs,
`endif
    output logic                o_ready,
    output logic                o_underrun,
    output logic                o_block_start,
    output logic                o_spdif
);

    localparam int         PAIR_W     = 2 * SAMPLE_W;
    localparam int         ALIGN_SH   = AUDIO_SLOT_W - SAMPLE_W;
    localparam logic [7:0] LAST_FRAME = FRAMES_PER_BLOCK - 8'd1;
    localparam logic [31:0] CS_PARAM  = build_cs(CATEGORY_CODE, COPY_BIT, L_BIT, SAMPLE_FREQ);

    // Serial position and line state.
    logic        half_r;
    logic [4:0]  slot_r;
    sub_t        sub_r;
    logic [7:0]  frame_r;
    logic        parity_r;
    logic        pre_inv_r;
    logic        spdif_r;
    logic        v_r;
    logic        underrun_r;
    logic        block_start_r;
    logic [23:0] ldata_r;
    logic [23:0] rdata_r;

    // FIFO interface.
    logic [PAIR_W-1:0] fifo_wdata_s;
    logic [PAIR_W-1:0] fifo_rdata_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    // Combinational datapath.
    logic        load_s;
    logic [31:0] cs_word_s;
    logic        cs_bit_s;
    logic [7:0]  pre_pat_s;
    logic [2:0]  pre_idx_s;
    logic        pre_inv_s;
    logic [23:0] sample_s;
    logic [4:0]  audio_idx_s;
    logic        bit_s;
    logic        level_s;
    logic [23:0] ldata_al_s;
    logic [23:0] rdata_al_s;

    assign fifo_wdata_s = {i_ldata, i_rdata};

    spdif_sample_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (i_valid),
        .wr_data (fifo_wdata_s),
        .rd_en   (load_s),
        .rd_data (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Left preamble load: the strobe that starts every frame and pops a pair.
    assign load_s = i_en_2x && (sub_r == SUB_LEFT) && (slot_r == 5'd0) && (half_r == 1'b0);

    // Samples are MSB-aligned in the 24-bit slot with zero LSBs.
    assign ldata_al_s = 24'(fifo_rdata_s[PAIR_W-1:SAMPLE_W]) << ALIGN_SH;
    assign rdata_al_s = 24'(fifo_rdata_s[SAMPLE_W-1:0]) << ALIGN_SH;

    assign o_ready       = !fifo_full_s;
    assign o_underrun    = underrun_r;
    assign o_block_start = block_start_r;
    assign o_spdif       = spdif_r;

`ifdef SPDIF_TX_CS_PORT_EN
    logic [31:0] cs_shadow_r;

    // Capture the run-time channel-status word at each block start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cs_shadow_r <= CS_PARAM;
        end else if (load_s && (frame_r == 8'd0)) begin
            cs_shadow_r <= i_cs;
        end
    end

    assign cs_word_s = cs_shadow_r;
`else
    assign cs_word_s = CS_PARAM;
`endif

    // Pick preamble, slot bit and the next half-cell line level.
    always_comb begin
        pre_pat_s   = PRE_Y;
        pre_idx_s   = {slot_r[1:0], half_r};
        pre_inv_s   = pre_inv_r;
        sample_s    = ldata_r;
        audio_idx_s = slot_r - SLOT_AUDIO0;
        cs_bit_s    = 1'b0;
        bit_s       = 1'b0;
        level_s     = 1'b0;

        if (sub_r == SUB_RIGHT) begin
            pre_pat_s = PRE_Y;
            sample_s  = rdata_r;
        end else if (frame_r == 8'd0) begin
            pre_pat_s = PRE_Z;
            sample_s  = ldata_r;
        end else begin
            pre_pat_s = PRE_X;
            sample_s  = ldata_r;
        end

        // The first preamble half-cell compares against the live line level.
        if ((slot_r == 5'd0) && (half_r == 1'b0)) begin
            pre_inv_s = spdif_r;
        end else begin
            pre_inv_s = pre_inv_r;
        end

        if (frame_r < CS_WORD_FRAMES) begin
            cs_bit_s = cs_word_s[5'd31 - frame_r[4:0]];
        end else begin
            cs_bit_s = 1'b0;
        end

        if (slot_r == SLOT_V) begin
            bit_s = v_r;
        end else if (slot_r == SLOT_U) begin
            bit_s = 1'b0;
        end else if (slot_r == SLOT_C) begin
            bit_s = cs_bit_s;
        end else if (slot_r == SLOT_P) begin
            bit_s = parity_r;
        end else if (slot_r >= SLOT_AUDIO0) begin
            bit_s = sample_s[audio_idx_s];
        end else begin
            bit_s = 1'b0;
        end

        if (slot_r < SLOT_AUDIO0) begin
            level_s = pre_pat_s[3'd7 - pre_idx_s] ^ pre_inv_s;
        end else if (half_r == 1'b0) begin
            level_s = !spdif_r;
        end else begin
            level_s = spdif_r ^ bit_s;
        end
    end

    // Advance line level, parity, held sample pair and slot/frame counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            half_r    <= 1'b0;
            slot_r    <= 5'd0;
            sub_r     <= SUB_LEFT;
            frame_r   <= 8'd0;
            parity_r  <= 1'b0;
            pre_inv_r <= 1'b0;
            spdif_r   <= 1'b0;
            v_r       <= 1'b0;
            ldata_r   <= 24'h000000;
            rdata_r   <= 24'h000000;
        end else if (i_en_2x) begin
            spdif_r <= level_s;
            half_r  <= !half_r;

            if ((slot_r == 5'd0) && (half_r == 1'b0)) begin
                pre_inv_r <= spdif_r;
            end

            // Parity runs over slots 4..30 so slot 31 makes the subframe even.
            if (half_r == 1'b0) begin
                if (slot_r == SLOT_PRE_LAST) begin
                    parity_r <= 1'b0;
                end else if ((slot_r >= SLOT_AUDIO0) && (slot_r != SLOT_P)) begin
                    parity_r <= parity_r ^ bit_s;
                end
            end

            if (load_s) begin
                if (fifo_empty_s) begin
                    ldata_r <= 24'h000000;
                    rdata_r <= 24'h000000;
                    v_r     <= 1'b1;
                end else begin
                    ldata_r <= ldata_al_s;
                    rdata_r <= rdata_al_s;
                    v_r     <= 1'b0;
                end
            end

            if (half_r == 1'b1) begin
                slot_r <= slot_r + 5'd1;
                if (slot_r == SLOT_P) begin
                    if (sub_r == SUB_LEFT) begin
                        sub_r <= SUB_RIGHT;
                    end else begin
                        sub_r   <= SUB_LEFT;
                        frame_r <= (frame_r == LAST_FRAME) ? 8'd0 : frame_r + 8'd1;
                    end
                end
            end
        end
    end

    // One-cycle status pulses aligned with the left preamble load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            underrun_r    <= 1'b0;
            block_start_r <= 1'b0;
        end else begin
            underrun_r    <= load_s && fifo_empty_s;
            block_start_r <= load_s && (frame_r == 8'd0);
        end
    end

endmodule

// File: tb/tb_spdif_tx_stream.sv
// Scoreboard bench for spdif_tx_stream: the stimulus queues expected sample
// pairs, a monitor decodes the biphase-mark line frame by frame and compares.
`timescale 1ns/1ps
module tb_spdif_tx_stream;

    localparam int          SW     = 24;
    localparam logic [31:0] CS_DEF = 32'h2060_0000;  // copy=1, category 0110000
    localparam logic [7:0]  PAT_Z  = 8'b11101000;
    localparam logic [7:0]  PAT_X  = 8'b11100010;
    localparam logic [7:0]  PAT_Y  = 8'b11100100;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_2x;
    logic [SW-1:0] ldata;
    logic [SW-1:0] rdata;
    logic          valid;
    logic          ready;
    logic          underrun;
    logic          block_start;
    logic          spdif;
`ifdef SPDIF_TX_CS_PORT_EN
    logic [31:0]   cs_in;
`endif

    int          n_vec = 0;
    int          n_fail = 0;
    logic [47:0] exp_q[$];
    int          en_div = 4;
    bit          en_on = 1'b0;
    int          epoch = 0;
    int          mon_frame = 0;
    int          mon_half = 0;
    int          model_cnt = 0;

    always #5 clk = ~clk;

    spdif_tx_stream dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en_2x       (en_2x),
        .i_ldata       (ldata),
        .i_rdata       (rdata),
        .i_valid       (valid),
`ifdef SPDIF_TX_CS_PORT_EN
        .i_cs          (cs_in),
`endif
        .o_ready       (ready),
        .o_underrun    (underrun),
        .o_block_start (block_start),
        .o_spdif       (spdif)
    );

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (epoch %0d frame %0d): got %0h, required %0h", name, epoch, mon_frame, act, req);
        end
    endtask

    // Decode and check one complete frame of 128 half-cells.
    task automatic check_frame(input logic [127:0] hv, input logic last_lv, input int ur_cnt, input int bs_cnt);
        int          fb;
        logic        exp_v;
        logic        exp_c;
        logic [31:0] csw;
        logic [23:0] aud[2];
        logic [47:0] pair;
        fb = mon_frame % 192;
        if (epoch == 0) exp_v = !(mon_frame < 4 || mon_frame == 11 || mon_frame == 12);
        else exp_v = 1'b1;
        csw = CS_DEF;
`ifdef SPDIF_TX_CS_PORT_EN
        if (epoch == 1) csw = 32'h0000_0001;
`endif
        exp_c = (fb < 32) ? csw[31 - fb] : 1'b0;
        for (int s = 0; s < 2; s++) begin
            logic       prev;
            logic [7:0] pre;
            logic [7:0] pat;
            logic [31:0] bits;
            int         bm;
            prev = (s == 0) ? last_lv : hv[63];
            for (int i = 0; i < 8; i++) pre[7 - i] = hv[64 * s + i];
            pat = (s == 1) ? PAT_Y : ((fb == 0) ? PAT_Z : PAT_X);
            check(s == 0 ? "preamble_left" : "preamble_right", {40'h0, pre}, {40'h0, prev ? ~pat : pat});
            bm = 0;
            bits = 32'h0;
            for (int k = 4; k < 32; k++) begin
                logic a;
                logic b;
                a = hv[64 * s + 2 * k];
                b = hv[64 * s + 2 * k + 1];
                if (a == hv[64 * s + 2 * k - 1]) bm++;
                bits[k] = a ^ b;
            end
            check("cell_transitions_missing", 48'(bm), 48'd0);
            check("parity_odd", {47'h0, ^bits[31:4]}, 48'd0);
            check("u_bit", {47'h0, bits[29]}, 48'd0);
            check("v_bit", {47'h0, bits[28]}, {47'h0, exp_v});
            check("c_bit", {47'h0, bits[30]}, {47'h0, exp_c});
            aud[s] = bits[27:4];
        end
        if (exp_v) begin
            check("zero_audio_left", {24'h0, aud[0]}, 48'd0);
            check("zero_audio_right", {24'h0, aud[1]}, 48'd0);
            check("underrun_pulses", 48'(ur_cnt), 48'd1);
        end else begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL scoreboard_empty (frame %0d): got valid audio, required a queued pair", mon_frame);
            end else begin
                pair = exp_q.pop_front();
                check("audio_left", {24'h0, aud[0]}, {24'h0, pair[47:24]});
                check("audio_right", {24'h0, aud[1]}, {24'h0, pair[23:0]});
            end
            check("underrun_pulses", 48'(ur_cnt), 48'd0);
        end
        check("block_start_pulses", 48'(bs_cnt), (fb == 0) ? 48'd1 : 48'd0);
    endtask

    // Half-cell strobe generator, one strobe every en_div clocks when enabled.
    initial begin : strobe_gen
        int c;
        c = 0;
        en_2x = 1'b0;
        forever begin
            @(negedge clk);
            c++;
            if (c >= en_div) c = 0;
            en_2x = en_on && (c == 0);
        end
    end

    // Monitor: collects line half-cells per strobe and checks each frame.
    initial begin : monitor
        logic [127:0] hv;
        logic         last_lv;
        int           ur_cnt;
        int           bs_cnt;
        logic         en_seen;
        hv = 128'h0;
        last_lv = 1'b0;
        ur_cnt = 0;
        bs_cnt = 0;
        forever begin
            @(posedge clk);
            en_seen = en_2x;
            #1;
            if (rst) begin
                mon_half = 0;
                mon_frame = 0;
                last_lv = 1'b0;
                ur_cnt = 0;
                bs_cnt = 0;
            end else begin
                if (underrun) ur_cnt++;
                if (block_start) bs_cnt++;
                if (en_seen) begin
                    hv[mon_half] = spdif;
                    mon_half++;
                    if (mon_half == 128) begin
                        check_frame(hv, last_lv, ur_cnt, bs_cnt);
                        last_lv = hv[127];
                        mon_half = 0;
                        mon_frame++;
                        ur_cnt = 0;
                        bs_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic wait_frame(input int target);
        int budget;
        budget = (target - mon_frame + 2) * 128 * en_div + 100;
        while (mon_frame < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (mon_frame < target) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_frame: reached frame %0d, required %0d", mon_frame, target);
        end
    endtask

    task automatic wait_half(input int target);
        int budget;
        budget = 200 * en_div;
        while (mon_half < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (mon_half < target) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_half: reached half-cell %0d, required %0d", mon_half, target);
        end
    endtask

    // Drive one pair for one clock; the model accepts it only with room.
    task automatic push(input logic [47:0] pair, input bit expect_out);
        ldata = pair[47:24];
        rdata = pair[23:0];
        valid = 1'b1;
        check("ready_before_push", {47'h0, ready}, (model_cnt < 4) ? 48'd1 : 48'd0);
        if (model_cnt < 4) begin
            model_cnt++;
            if (expect_out) exp_q.push_back(pair);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin : stimulus
        rst = 1'b1;
        valid = 1'b0;
        ldata = '0;
        rdata = '0;
`ifdef SPDIF_TX_CS_PORT_EN
        cs_in = CS_DEF;
`endif
        repeat (3) @(negedge clk);
        check("reset_ready", {47'h0, ready}, 48'd1);
        check("reset_spdif", {47'h0, spdif}, 48'd0);
        check("reset_underrun", {47'h0, underrun}, 48'd0);
        check("reset_block_start", {47'h0, block_start}, 48'd0);
        rst = 1'b0;
        @(negedge clk);

        // Five back-to-back pushes with the line frozen: the fifth is dropped.
        push({24'h123456, 24'hABCDEF}, 1'b1);
        push({24'hFFFFFF, 24'h000001}, 1'b1);
        push({24'h800000, 24'h7FFFFF}, 1'b1);
        push({24'hA5A5A5, 24'h5A5A5A}, 1'b1);
        push({24'h111111, 24'h222222}, 1'b1);
        check("ready_when_full", {47'h0, ready}, 48'd0);

        // Frames 0-3 carry the four queued pairs, then underrun.
        en_div = 4;
        en_on = 1'b1;
        wait_frame(8);
        en_div = 1;
        wait_frame(10);
        wait_half(64);
        model_cnt = 0;
        push({24'h000001, 24'h800000}, 1'b1);
        push({24'h5A5A5A, 24'hC3C3C3}, 1'b1);

        // Run past the second block start.
        wait_frame(196);
        wait_half(20);
        en_on = 1'b0;
        @(negedge clk);

        // Fill the FIFO, then reset mid-subframe: everything is discarded.
        model_cnt = 0;
        push({24'h0F0F0F, 24'hF0F0F0}, 1'b0);
        push({24'h0F0F0F, 24'hF0F0F0}, 1'b0);
        push({24'h0F0F0F, 24'hF0F0F0}, 1'b0);
        push({24'h0F0F0F, 24'hF0F0F0}, 1'b0);
        check("ready_full_before_reset", {47'h0, ready}, 48'd0);
        #2;
        rst = 1'b1;
        #1;
        check("spdif_low_in_reset", {47'h0, spdif}, 48'd0);
        check("ready_in_reset", {47'h0, ready}, 48'd1);
        epoch = 1;
        model_cnt = 0;
`ifdef SPDIF_TX_CS_PORT_EN
        cs_in = 32'h0000_0001;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        en_on = 1'b1;
        wait_frame(33);

        check("pairs_left_unsent", 48'(exp_q.size()), 48'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
